// File: rtl/gpio_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_ctrl
// Parametrised GPIO peripheral on the router register port. It provides pad
// output/tristate control, synchronised (optionally debounced) pad input
// sampling, set/clear aliases for DATA, and per-pin edge-detect interrupts
// with a write-1-to-clear status register and a level irq to the core.
//
// Build option: define GPIO_DEBOUNCE_EN to insert a per-pin stability filter
// between the synchroniser and the edge detector. Without it, the
// synchroniser output feeds the edge detector directly and no counters exist.
//
// Ports
//   clk               core clock
//   reset             synchronous, active-high
//   reg_en            access strobe, one cycle per access
//   reg_rwn           1 = read, 0 = write
//   reg_addr[3:0]     word address
//   reg_wben[3:0]     per-byte write enables
//   reg_write[31:0]   write data
//   reg_read[31:0]    read data, registered, held between reads
//   ro_gpio_pinstate  raw asynchronous pad inputs
//   rf_gpio_datareg   pad output values
//   rf_gpio_tristate  1 = pad high-Z, 0 = driven
//   gpio_irq          registered |(IRQ_STATUS & IRQ_MASK)
// -----------------------------------------------------------------------------
module gpio_ctrl #(
    parameter int GPIO_WIDTH      = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_en,
    input  logic                  reg_rwn,
    input  logic [3:0]            reg_addr,
    input  logic [3:0]            reg_wben,
    input  logic [31:0]           reg_write,
    output logic [31:0]           reg_read,
    input  logic [GPIO_WIDTH-1:0] ro_gpio_pinstate,
    output logic [GPIO_WIDTH-1:0] rf_gpio_datareg,
    output logic [GPIO_WIDTH-1:0] rf_gpio_tristate,
    output logic                  gpio_irq
);

    localparam logic [3:0] ADDR_DATA   = 4'd0;
    localparam logic [3:0] ADDR_TRIS   = 4'd1;
    localparam logic [3:0] ADDR_PIN    = 4'd2;
    localparam logic [3:0] ADDR_MASK   = 4'd3;
    localparam logic [3:0] ADDR_POL    = 4'd4;
    localparam logic [3:0] ADDR_STATUS = 4'd5;
    localparam logic [3:0] ADDR_SET    = 4'd6;
    localparam logic [3:0] ADDR_CLR    = 4'd7;

    // Edge detection stays off until the whole input path has filled with
    // real pad values, so pads already high at reset release raise nothing.
`ifdef GPIO_DEBOUNCE_EN
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int ARM_W = $clog2(ARM_CYCLES + 1);

    logic [GPIO_WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] data_r, tris_r, mask_r, pol_r, status_r, prev_q_r;
    logic [ARM_W-1:0]      arm_cnt_r;
    logic                  irq_r;
    logic [31:0]           read_r;

    logic [31:0]           wmask_s, wr_bits_s, rd_data_s;
    logic [GPIO_WIDTH-1:0] wr_s, pin_q_s, sync_out_s, event_s, w1c_s, status_next_s;
    logic                  wr_en_s, rd_en_s, armed_s;
    logic                  unused_s;

    // Zero-extend a pin-wide value onto the 32-bit read bus.
    function automatic logic [31:0] pad32(input logic [GPIO_WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    assign wr_en_s    = reg_en & ~reg_rwn;
    assign rd_en_s    = reg_en & reg_rwn;
    assign wmask_s    = {{8{reg_wben[3]}}, {8{reg_wben[2]}}, {8{reg_wben[1]}}, {8{reg_wben[0]}}};
    assign wr_bits_s  = reg_write & wmask_s;
    // Register bits above GPIO_WIDTH are simply dropped here.
    assign wr_s       = wr_bits_s[GPIO_WIDTH-1:0];
    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign armed_s    = (arm_cnt_r == ARM_W'(ARM_CYCLES));
    assign unused_s   = ^{wr_bits_s, DEBOUNCE_CYCLES[0]};

    // Pad input synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
        end else begin
            sync_r[0] <= ro_gpio_pinstate;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [GPIO_WIDTH-1:0] pin_q_r;
    logic [CNT_W-1:0]      db_cnt_r [GPIO_WIDTH];

    // Per-pin debounce: accept a new level only after it has persisted for
    // DEBOUNCE_CYCLES consecutive samples; any return to pin_q restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            pin_q_r <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) db_cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (sync_out_s[i] == pin_q_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    pin_q_r[i]  <= sync_out_s[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1'b1);
                end
            end
        end
    end

    assign pin_q_s = pin_q_r;
`else
    assign pin_q_s = sync_out_s;
`endif

    // Edge events and next IRQ_STATUS; a same-cycle event beats a W1C.
    always_comb begin
        event_s = '0;
        w1c_s   = '0;
        if (armed_s) begin
            event_s = (pol_r & ~pin_q_s & prev_q_r) | (~pol_r & pin_q_s & ~prev_q_r);
        end else begin
            event_s = '0;
        end
        if (wr_en_s && (reg_addr == ADDR_STATUS)) begin
            w1c_s = wr_s;
        end else begin
            w1c_s = '0;
        end
        status_next_s = (status_r & ~w1c_s) | event_s;
    end

    // Read data mux; write-only and unmapped addresses return zero.
    always_comb begin
        rd_data_s = 32'h0;
        case (reg_addr)
            ADDR_DATA:   rd_data_s = pad32(data_r);
            ADDR_TRIS:   rd_data_s = pad32(tris_r);
            ADDR_PIN:    rd_data_s = pad32(pin_q_s);
            ADDR_MASK:   rd_data_s = pad32(mask_r);
            ADDR_POL:    rd_data_s = pad32(pol_r);
            ADDR_STATUS: rd_data_s = pad32(status_r);
            default:     rd_data_s = 32'h0;
        endcase
    end

    // Register file, edge history, arming counter, read port and irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r    <= '0;
            tris_r    <= '1;
            mask_r    <= '0;
            pol_r     <= '0;
            status_r  <= '0;
            prev_q_r  <= '0;
            arm_cnt_r <= '0;
            irq_r     <= 1'b0;
            read_r    <= 32'h0;
        end else begin
            prev_q_r <= pin_q_s;
            status_r <= status_next_s;
            irq_r    <= |(status_r & mask_r);
            if (!armed_s) begin
                arm_cnt_r <= arm_cnt_r + ARM_W'(1'b1);
            end
            if (wr_en_s) begin
                case (reg_addr)
                    ADDR_DATA: data_r <= (data_r & ~wmask_s[GPIO_WIDTH-1:0]) | wr_s;
                    ADDR_TRIS: tris_r <= (tris_r & ~wmask_s[GPIO_WIDTH-1:0]) | wr_s;
                    ADDR_MASK: mask_r <= (mask_r & ~wmask_s[GPIO_WIDTH-1:0]) | wr_s;
                    ADDR_POL:  pol_r  <= (pol_r  & ~wmask_s[GPIO_WIDTH-1:0]) | wr_s;
                    ADDR_SET:  data_r <= data_r | wr_s;
                    ADDR_CLR:  data_r <= data_r & ~wr_s;
                    default:   ;
                endcase
            end
            if (rd_en_s) begin
                read_r <= rd_data_s;
            end
        end
    end

    assign reg_read         = read_r;
    assign rf_gpio_datareg  = data_r;
    assign rf_gpio_tristate = tris_r;
    assign gpio_irq         = irq_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_ctrl
// Directed self-checking bench for gpio_ctrl (default parameters). Inputs are
// driven 1 time unit after the rising edge and outputs sampled at that point.
// When GPIO_DEBOUNCE_EN is defined the input-path latency grows by 8 cycles
// and the debounce scenarios are added.
// -----------------------------------------------------------------------------
module tb_gpio_ctrl;

`ifdef GPIO_DEBOUNCE_EN
    localparam int EXTRA = 8;
`else
    localparam int EXTRA = 0;
`endif
    localparam int SETTLE = 6 + EXTRA;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_en, reg_rwn;
    logic [3:0]  reg_addr, reg_wben;
    logic [31:0] reg_write, reg_read;
    logic [15:0] pins, datareg, tris;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;

    gpio_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .reg_en           (reg_en),
        .reg_rwn          (reg_rwn),
        .reg_addr         (reg_addr),
        .reg_wben         (reg_wben),
        .reg_write        (reg_write),
        .reg_read         (reg_read),
        .ro_gpio_pinstate (pins),
        .rf_gpio_datareg  (datareg),
        .rf_gpio_tristate (tris),
        .gpio_irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        reg_en = 1'b1; reg_rwn = 1'b0; reg_addr = a; reg_write = d; reg_wben = be;
        tick(1);
        reg_en = 1'b0; reg_rwn = 1'b1; reg_wben = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        reg_en = 1'b1; reg_rwn = 1'b1; reg_addr = a;
        tick(1);
        reg_en = 1'b0;
        chk(tag, reg_read, exp);
    endtask

    initial begin
        reset = 1'b1; reg_en = 1'b0; reg_rwn = 1'b1; reg_addr = 4'h0;
        reg_wben = 4'h0; reg_write = 32'h0; pins = 16'hFFFF;

        // Reset state with all pads high
        tick(3);
        chk("rst_tris", {16'h0, tris}, 32'h0000_FFFF);
        chk("rst_data", {16'h0, datareg}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_read", reg_read, 32'h0);
        reset = 1'b0;
        tick(SETTLE + 4);
        rd_chk("arm_status", 4'd5, 32'h0);
        rd_chk("pin_high", 4'd2, 32'h0000_FFFF);

        // Falling edges with rising polarity raise nothing
        pins = 16'h0000;
        tick(SETTLE);
        rd_chk("fall_pol0", 4'd5, 32'h0);
        rd_chk("pin_low", 4'd2, 32'h0);

        // Byte writes and set/clear aliases
        reg_wr(4'd0, 32'h0000_A55A, 4'b0001);
        rd_chk("byte_wr", 4'd0, 32'h0000_005A);
        chk("byte_wr_pad", {16'h0, datareg}, 32'h0000_005A);
        reg_wr(4'd6, 32'h0000_0F00, 4'b1111);
        rd_chk("data_set", 4'd0, 32'h0000_0F5A);
        reg_wr(4'd7, 32'h0000_000A, 4'b1111);
        rd_chk("data_clr", 4'd0, 32'h0000_0F50);
        reg_wr(4'd0, 32'h0000_FFFF, 4'b0000);
        rd_chk("wben0", 4'd0, 32'h0000_0F50);
        reg_wr(4'd1, 32'h0000_12FF, 4'b0010);
        chk("tris_byte1", {16'h0, tris}, 32'h0000_12FF);
        rd_chk("unmapped12", 4'd12, 32'h0);
        rd_chk("wo_set_rd", 4'd6, 32'h0);
        reg_wr(4'd3, 32'hFFFF_FFFF, 4'b1111);
        rd_chk("mask_upper", 4'd3, 32'h0000_FFFF);
        reg_wr(4'd3, 32'h0000_0001, 4'b1111);

        // Rising event on pad0: status at +3, irq at +4
        pins = 16'h0001;
        tick(2 + EXTRA);
        rd_chk("rise_early", 4'd5, 32'h0);
        chk("irq_early", {31'h0, irq}, 32'h0);
        rd_chk("rise_status", 4'd5, 32'h0000_0001);
        chk("irq_rise", {31'h0, irq}, 32'h1);
        reg_wr(4'd5, 32'h0000_0001, 4'b1111);
        chk("irq_hold_w1c", {31'h0, irq}, 32'h1);
        tick(1);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        rd_chk("w1c_status", 4'd5, 32'h0);

        // Falling polarity on pad2, unmasked
        reg_wr(4'd4, 32'h0000_0004, 4'b1111);
        pins = 16'h0005;
        tick(SETTLE);
        rd_chk("rise_on_fallpol", 4'd5, 32'h0);
        pins = 16'h0001;
        tick(SETTLE);
        rd_chk("fall_status", 4'd5, 32'h0000_0004);
        chk("irq_unmasked", {31'h0, irq}, 32'h0);
        reg_wr(4'd3, 32'h0000_0005, 4'b1111);
        chk("irq_mask_lat", {31'h0, irq}, 32'h0);
        tick(1);
        chk("irq_mask_on", {31'h0, irq}, 32'h1);
        reg_wr(4'd5, 32'h0000_0004, 4'b1111);
        tick(1);
        chk("irq_clr2", {31'h0, irq}, 32'h0);
        rd_chk("w1c_status2", 4'd5, 32'h0);

        // Changing polarity alone creates no event
        reg_wr(4'd4, 32'h0000_FFFF, 4'b1111);
        tick(SETTLE);
        rd_chk("pol_change", 4'd5, 32'h0);
        reg_wr(4'd4, 32'h0000_0000, 4'b1111);

        // W1C in the same cycle a new rising event lands: set wins
        pins = 16'h0000;
        tick(SETTLE);
        rd_chk("pre_collide", 4'd5, 32'h0);
        pins = 16'h0001;
        tick(2 + EXTRA);
        reg_wr(4'd5, 32'h0000_0001, 4'b1111);
        rd_chk("collision", 4'd5, 32'h0000_0001);
        chk("collision_irq", {31'h0, irq}, 32'h1);
        reg_wr(4'd5, 32'h0000_0001, 4'b1111);
        rd_chk("post_collide", 4'd5, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Short glitch on pad3 is filtered out
        pins = 16'h0009;
        tick(5);
        pins = 16'h0001;
        tick(20);
        rd_chk("db_glitch_pin", 4'd2, 32'h0000_0001);
        rd_chk("db_glitch_st", 4'd5, 32'h0);
        // Long level on pad3 is accepted after 2+8 cycles
        pins = 16'h0009;
        tick(9);
        rd_chk("db_pin_early", 4'd2, 32'h0000_0001);
        rd_chk("db_pin_level", 4'd2, 32'h0000_0009);
        tick(1);
        pins = 16'h0001;
        tick(20);
        rd_chk("db_status_once", 4'd5, 32'h0000_0008);
        reg_wr(4'd5, 32'h0000_0008, 4'b1111);
`endif

        // Reset during a write access discards it
        reg_wr(4'd6, 32'h0000_00F0, 4'b1111);
        chk("pre_rst_data", {16'h0, datareg}, 32'h0000_0FF0);
        reg_en = 1'b1; reg_rwn = 1'b0; reg_addr = 4'd0;
        reg_write = 32'h0000_FFFF; reg_wben = 4'b1111; reset = 1'b1;
        tick(1);
        reg_en = 1'b0; reg_rwn = 1'b1; reg_wben = 4'h0; reset = 1'b0;
        chk("midrst_data", {16'h0, datareg}, 32'h0);
        chk("midrst_tris", {16'h0, tris}, 32'h0000_FFFF);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        chk("midrst_read", reg_read, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
